// File: rtl/lif_scheduler.sv
// lif_scheduler: four virtual leaky integrate-and-fire neurons sharing one
// update datapath. A round-robin arbiter accepts one current per two cycles.
// The accepted neuron's membrane and refractory state are updated in the
// following cycle, and the result is presented as a registered one-cycle pulse.
module lif_scheduler #(
    parameter int         N_NEURONS  = 4,
    parameter logic [7:0] THRESHOLD  = 8'd200,
    parameter int         LEAK_SHIFT = 1,
    parameter logic [1:0] REFRACT    = 2'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_current,
    output logic [3:0]  req_ready,
    output logic        spike_valid,
    output logic        spike,
    output logic [1:0]  spike_id,
    output logic [7:0]  state_out,
    output logic        busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } fsm_t;

    fsm_t       fsm_q;
    logic [7:0] mem_q   [N_NEURONS];
    logic [1:0] refr_q  [N_NEURONS];
    logic [1:0] last_grant_q;
    logic [1:0] idx_q;
    logic [7:0] cur_q;
    logic       spike_valid_q;
    logic       spike_q;
    logic [1:0] spike_id_q;
    logic [7:0] state_out_q;

    logic [3:0] grant_oh_s;
    logic [1:0] grant_idx_s;
    logic [1:0] cand_s;
    logic       found_s;

    logic [7:0] mem_sel_s;
    logic [7:0] leak_s;
    logic [8:0] sum9_s;
    logic [7:0] sat_s;
    logic [7:0] mem_d;
    logic [1:0] refr_d;
    logic       spike_d;

    // Round-robin search starting one past the last accepted neuron.
    always_comb begin
        grant_oh_s  = 4'b0000;
        grant_idx_s = last_grant_q;
        found_s     = 1'b0;
        cand_s      = 2'd0;
        for (int k = 1; k <= N_NEURONS; k++) begin
            cand_s = last_grant_q + 2'(k);
            if (!found_s && req_valid[cand_s]) begin
                found_s     = 1'b1;
                grant_idx_s = cand_s;
                grant_oh_s  = 4'b0001 << cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Grant is offered only while idle, and never while reset is held.
    always_comb begin
        if (fsm_q == IDLE && !reset) begin
            req_ready = grant_oh_s;
        end else begin
            req_ready = 4'b0000;
        end
    end

    // Leak, integrate and saturate for the neuron latched at acceptance.
    always_comb begin
        mem_sel_s = mem_q[idx_q];
        leak_s    = mem_sel_s >> LEAK_SHIFT;
        sum9_s    = {1'b0, mem_sel_s} - {1'b0, leak_s} + {1'b0, cur_q};
        sat_s     = sum9_s[8] ? 8'hFF : sum9_s[7:0];
        if (refr_q[idx_q] != 2'd0) begin
            // Refractory: the current is discarded and the membrane is held at 0.
            refr_d  = refr_q[idx_q] - 2'd1;
            mem_d   = 8'd0;
            spike_d = 1'b0;
        end else if (sat_s >= THRESHOLD) begin
            refr_d  = REFRACT;
            mem_d   = 8'd0;
            spike_d = 1'b1;
        end else begin
            refr_d  = 2'd0;
            mem_d   = sat_s;
            spike_d = 1'b0;
        end
    end

    // Scheduler FSM, neuron state storage and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q         <= IDLE;
            last_grant_q  <= 2'd3;
            idx_q         <= 2'd0;
            cur_q         <= 8'd0;
            spike_valid_q <= 1'b0;
            spike_q       <= 1'b0;
            spike_id_q    <= 2'd0;
            state_out_q   <= 8'd0;
            for (int i = 0; i < N_NEURONS; i++) begin
                mem_q[i]  <= 8'd0;
                refr_q[i] <= 2'd0;
            end
        end else begin
            case (fsm_q)
                IDLE: begin
                    spike_valid_q <= 1'b0;
                    if (found_s) begin
                        cur_q        <= req_current[{grant_idx_s, 3'b000} +: 8];
                        idx_q        <= grant_idx_s;
                        last_grant_q <= grant_idx_s;
                        fsm_q        <= UPDATE;
                    end else begin
                        fsm_q <= IDLE;
                    end
                end
                UPDATE: begin
                    mem_q[idx_q]  <= mem_d;
                    refr_q[idx_q] <= refr_d;
                    spike_valid_q <= 1'b1;
                    spike_q       <= spike_d;
                    spike_id_q    <= idx_q;
                    state_out_q   <= mem_d;
                    fsm_q         <= IDLE;
                end
                default: begin
                    spike_valid_q <= 1'b0;
                    fsm_q         <= IDLE;
                end
            endcase
        end
    end

    assign spike_valid = spike_valid_q;
    assign spike       = spike_q;
    assign spike_id    = spike_id_q;
    assign state_out   = state_out_q;
    assign busy        = (fsm_q == UPDATE);

endmodule

// File: tb/tb_lif_scheduler.sv
// Scoreboard bench for lif_scheduler: stimulus pushes hand-computed results,
// and per-instance monitors pop and compare on every spike_valid pulse.
// Between pulses, the monitors check that the outputs hold their last values.
module tb_lif_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid, req_valid2;
    logic [31:0] req_current, req_current2;
    logic [3:0]  req_ready, req_ready2;
    logic        spike_valid, spike_valid2;
    logic        spike, spike2;
    logic [1:0]  spike_id, spike_id2;
    logic [7:0]  state_out, state_out2;
    logic        busy, busy2;

    int checks = 0;
    int errors = 0;

    logic [10:0] sb0 [$];
    logic [10:0] sb1 [$];

    always #5 clk = ~clk;

    lif_scheduler dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_current(req_current),
        .req_ready(req_ready), .spike_valid(spike_valid), .spike(spike),
        .spike_id(spike_id), .state_out(state_out), .busy(busy)
    );

    lif_scheduler #(.THRESHOLD(8'd255)) dut_sat (
        .clk(clk), .reset(reset), .req_valid(req_valid2), .req_current(req_current2),
        .req_ready(req_ready2), .spike_valid(spike_valid2), .spike(spike2),
        .spike_id(spike_id2), .state_out(state_out2), .busy(busy2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor for the default instance.
    initial begin
        logic [10:0] held0, e0;
        held0 = 11'd0;
        forever begin
            @(posedge clk); #1;
            if (reset) held0 = 11'd0;
            if (spike_valid) begin
                if (sb0.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pulse0_unexpected got={%0b,%0d,%0d}", spike, spike_id, state_out);
                end else begin
                    e0 = sb0.pop_front();
                    check("pulse0", {21'd0, spike, spike_id, state_out}, {21'd0, e0});
                    held0 = e0;
                end
            end else begin
                check("hold0", {21'd0, spike, spike_id, state_out}, {21'd0, held0});
            end
        end
    end

    // Monitor for the saturation instance.
    initial begin
        logic [10:0] held1, e1;
        held1 = 11'd0;
        forever begin
            @(posedge clk); #1;
            if (reset) held1 = 11'd0;
            if (spike_valid2) begin
                if (sb1.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pulse1_unexpected got={%0b,%0d,%0d}", spike2, spike_id2, state_out2);
                end else begin
                    e1 = sb1.pop_front();
                    check("pulse1", {21'd0, spike2, spike_id2, state_out2}, {21'd0, e1});
                    held1 = e1;
                end
            end else begin
                check("hold1", {21'd0, spike2, spike_id2, state_out2}, {21'd0, held1});
            end
        end
    end

    // Single request to neuron id on instance inst, with expected result.
    task automatic send(input int inst, input int id, input logic [7:0] cur,
                        input logic exp_sp, input logic [7:0] exp_st);
        logic [1:0] id2;
        logic [3:0] oh;
        id2 = id[1:0];
        oh  = 4'b0001 << id2;
        @(negedge clk);
        if (inst == 0) begin
            req_valid = oh; req_current = 32'd0; req_current[8*id +: 8] = cur;
            sb0.push_back({exp_sp, id2, exp_st});
        end else begin
            req_valid2 = oh; req_current2 = 32'd0; req_current2[8*id +: 8] = cur;
            sb1.push_back({exp_sp, id2, exp_st});
        end
        #1;
        check("ready_grant", {28'd0, (inst == 0) ? req_ready : req_ready2}, {28'd0, oh});
        check("busy_idle", {31'd0, (inst == 0) ? busy : busy2}, 32'd0);
        @(negedge clk);
        req_valid = 4'b0000; req_valid2 = 4'b0000;
        check("busy_update", {31'd0, (inst == 0) ? busy : busy2}, 32'd1);
        check("ready_update", {28'd0, (inst == 0) ? req_ready : req_ready2}, 32'd0);
    endtask

    // One round-robin step with all requests held high on the default instance.
    task automatic rr_step(input int id, input logic [7:0] exp_st);
        logic [1:0] id2;
        id2 = id[1:0];
        #1;
        check("rr_ready", {28'd0, req_ready}, {28'd0, 4'b0001 << id2});
        check("rr_busy_idle", {31'd0, busy}, 32'd0);
        sb0.push_back({1'b0, id2, exp_st});
        @(negedge clk);
        #1;
        check("rr_ready_update", {28'd0, req_ready}, 32'd0);
        check("rr_busy_update", {31'd0, busy}, 32'd1);
    endtask

    task automatic reset_pulse();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 4'hF; req_current = 32'hFFFF_FFFF;
        req_valid2 = 4'hF; req_current2 = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        #1;
        check("reset_ready", {28'd0, req_ready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_spike_valid", {31'd0, spike_valid}, 32'd0);
        check("reset_outputs", {21'd0, spike, spike_id, state_out}, 32'd0);
        req_valid = 4'b0000; req_valid2 = 4'b0000;
        req_current = 32'd0; req_current2 = 32'd0;
        reset = 1'b0;

        // Round robin from reset: 0,1,2,3 then 0 again (10-5+10=15).
        @(negedge clk);
        req_valid = 4'hF; req_current = {4{8'd10}};
        rr_step(0, 8'd10); @(negedge clk);
        rr_step(1, 8'd10); @(negedge clk);
        rr_step(2, 8'd10); @(negedge clk);
        rr_step(3, 8'd10); @(negedge clk);
        rr_step(0, 8'd15);
        req_valid = 4'b0000;
        reset_pulse();

        // Neuron 0: 150, then 150-75+150=225 >= 200 spikes.
        send(0, 0, 8'd150, 1'b0, 8'd150);
        send(0, 0, 8'd150, 1'b1, 8'd0);
        // Neuron 1: 100, then leak only.
        send(0, 1, 8'd100, 1'b0, 8'd100);
        send(0, 1, 8'd0,   1'b0, 8'd50);
        // Neuron 2: spike, two refractory updates, then spike again.
        send(0, 2, 8'd255, 1'b1, 8'd0);
        send(0, 2, 8'd255, 1'b0, 8'd0);
        send(0, 2, 8'd255, 1'b0, 8'd0);
        send(0, 2, 8'd255, 1'b1, 8'd0);
        // Exact threshold spikes: neuron 3 at 0 plus 200.
        send(0, 3, 8'd200, 1'b1, 8'd0);
        send(0, 3, 8'd0,   1'b0, 8'd0);
        send(0, 3, 8'd0,   1'b0, 8'd0);
        send(0, 3, 8'd100, 1'b0, 8'd100);
        // Just below threshold: neuron 1 at 50 becomes 25 plus 174 = 199.
        send(0, 1, 8'd174, 1'b0, 8'd199);

        // Abort an update of neuron 3 with reset; no pulse expected.
        @(negedge clk);
        req_valid = 4'b1000; req_current = {8'd77, 24'd0};
        @(negedge clk);
        req_valid = 4'b0000; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        // All states cleared and priority back at neuron 0: 0-0+1 = 1 each.
        @(negedge clk);
        req_valid = 4'hF; req_current = {4{8'd1}};
        rr_step(0, 8'd1); @(negedge clk);
        rr_step(1, 8'd1); @(negedge clk);
        rr_step(2, 8'd1); @(negedge clk);
        rr_step(3, 8'd1);
        req_valid = 4'b0000;

        // Saturation with THRESHOLD = 255: 200, then 300 saturated to 255 spikes.
        send(1, 0, 8'd200, 1'b0, 8'd200);
        send(1, 0, 8'd200, 1'b1, 8'd0);

        repeat (6) @(negedge clk);
        check("sb0_drained", sb0.size(), 32'd0);
        check("sb1_drained", sb1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
